instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//  Front end of the in-order core. Fetches 32-bit instructions from instruction memory
//  and buffers them with their PC. Presents them to the ID stage (instruction decoder)
//  through a valid/ready interface. Branch/jump resolution redirects the PC, flushing
//  the buffer and dropping in-flight fetches.
// PARAMETERS
//  XLEN        32             address/PC width
//  RESET_PC    32'h0000_0000  first fetch address after reset
//  FIFO_DEPTH  4              instruction buffer entries; power of 2, >=2
// PORTS
//  clk             in   1     core clock, all state on rising edge
//  reset_n         in   1     asynchronous, active-low reset
//  imem_req_valid  out  1     fetch request valid
//  imem_req_ready  in   1     memory accepts request
//  imem_req_addr   out  XLEN  fetch address, word aligned
//  imem_rsp_valid  in   1     response valid; one per accepted request, in order
//  imem_rsp_data   in   32    instruction word
//  imem_rsp_err    in   1     access fault for this response
//  redirect_valid  in   1     taken branch/jump from execute
//  redirect_pc     in   XLEN  target PC
//  id_valid        out  1     buffer head valid
//  id_ready        in   1     ID stage accepts head
//  id_instr        out  32    instruction word (decoder slices opcode/funct3/funct7)
//  id_pc           out  XLEN  PC of id_instr
//  id_fault        out  1     entry carries a fetch fault; id_instr is NOP
// BEHAVIOUR
//  - Reset values: pc_q=RESET_PC, state=IDLE, FIFO empty. imem_req_valid=0, imem_req_addr=0.
//    id_valid=0, id_instr=0, id_pc=0, id_fault=0.
//  - At most 1 outstanding request. Throughput is 1 instr per 2 cycles at 1-cycle memory latency.
//  - FSM IDLE: if (fifo_count < FIFO_DEPTH), go to REQ next cycle.
//  - FSM REQ: imem_req_valid=1, imem_req_addr=pc_q. Addr is held stable until handshake.
//    On valid&&ready: pc_q += 4 (wraps FFFF_FFFC->0); go to WAIT.
//  - FSM WAIT: on imem_rsp_valid, push {pc, data, err} into the FIFO.
//    Go to REQ if space remains after the push, else IDLE.
//  - FSM DRAIN: waits for the stale response; discards it; then goes to REQ.
//  - imem_rsp_valid is ignored outside WAIT/DRAIN.
//  - imem_rsp_err=1: entry pushed with id_fault=1, id_instr=32'h0000_0013 (NOP). Fetch continues.
//  - FIFO pop: id_valid && id_ready. Push and pop in the same cycle are both legal when full.
//  - Redirect has highest priority. It flushes the FIFO (id_valid=0 next cycle) and sets pc_q=redirect_pc.
//    - IDLE/REQ without handshake: next state REQ. An un-accepted request is withdrawn.
//    - REQ with handshake in the same cycle, or WAIT without rsp: next state DRAIN.
//    - WAIT with rsp_valid in the same cycle: rsp dropped; next state REQ.
//    - DRAIN: new target replaces the old; stays in DRAIN.
//    - Redirect + pop in the same cycle: flush wins; pop is a no-op.
//  - Latency: reset release (cycle 0) -> REQ cycle 1 -> rsp cycle 2 -> id_valid=1 cycle 3
//    (req_ready=1, 1-cycle memory).
//  - reset_n asserted mid-operation: immediate return to reset values. A pending memory
//    response is the memory's responsibility to cancel on the same reset.
// CONFIGURATION
//  IFETCH_MISALIGN_CHK_EN:
//   - Defined: redirect_pc[1:0]!=0 issues no fetch. One entry is pushed
//     {pc=redirect_pc, NOP, fault=1}. FSM enters HALT; only a new redirect leaves HALT.
//   - Undefined: redirect_pc[1:0] forced to 2'b00; no HALT state exists.
// STRUCTURE
//  - cpu_types_pkg:
//    - NOP_INSTR=32'h0000_0013, RESET_VECTOR
//    - fetch_state_t enum {IDLE,REQ,WAIT,DRAIN,HALT}
//    - fetch_entry_t struct {pc, instr, fault}
//  - Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t with a single-cycle flush,
//    count output, and registered head.
// TESTING
//  - Reset, req_ready=1, 1-cycle memory returning 32'h00500093 -> first req addr 0.
//    id_valid at cycle 3: id_pc=0, id_instr=00500093. Second req addr 4.
//  - id_ready=0 held -> exactly FIFO_DEPTH (4) entries buffered, PCs 0,4,8,C.
//    No 5th request issued until one pop.
//  - Redirect to 32'h100 in the same cycle as a request handshake at addr 8.
//    -> FIFO emptied; stale rsp for 8 discarded (DRAIN); next req addr 100.
//    First id_pc=100.
//  - Redirect coincident with rsp_valid in WAIT -> rsp dropped; req at target next cycle.
//    No stale entry reaches ID.
//  - rsp_err=1 for addr 0xC -> id_pc=C, id_fault=1, id_instr=0000_0013. Next fetch addr 10.
//  - With IFETCH_MISALIGN_CHK_EN, redirect to 32'h102 -> single fault entry pc=102.
//    No imem request until the next redirect. Without it, fetch addr is 100.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types and constants for the instruction fetch front end.
// The HALT fetch state exists only when IFETCH_MISALIGN_CHK_EN is defined.
package cpu_types_pkg;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

`ifdef IFETCH_MISALIGN_CHK_EN
    typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, HALT} fetch_state_t;
`else
    typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN} fetch_state_t;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Purpose: in-order buffer of fetch entries between fetch and decode, single-cycle flush.
// Latency: a push is visible at the head the next cycle; head comes straight from entry registers.
// Backpressure: push dropped when full unless a pop frees a slot that cycle; flush beats pop.
module fetch_fifo
    import cpu_types_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    flush,
    input  logic                    push,
    input  fetch_entry_t            push_entry,
    input  logic                    pop,
    output logic                    head_valid,
    output fetch_entry_t            head_entry,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t   mem_q [DEPTH];
    logic [AW-1:0]  rd_ptr_q;
    logic [AW-1:0]  wr_ptr_q;
    logic [AW:0]    count_q;
    logic           full;
    logic           do_push;
    logic           do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop && (count_q != '0) && !flush;
    assign do_push = push && (flush || !full || do_pop);

    // A push alongside a flush becomes the sole surviving entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= AW'(do_push);
            count_q  <= (AW+1)'(do_push);
            if (do_push) begin
                mem_q[0] <= push_entry;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_entry;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    assign head_valid = (count_q != '0);
    assign head_entry = mem_q[rd_ptr_q];
    assign count      = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Purpose: fetch front end, one outstanding imem request, buffers {pc, instr, fault} for decode.
// Latency: 3 cycles from reset release to first id_valid with a 1-cycle memory; 1 instr per 2 cycles.
// Backpressure: no request issued while the buffer is full; redirect flushes and drops in-flight data.
// Build option IFETCH_MISALIGN_CHK_EN: a misaligned redirect yields one fault entry and halts fetch.
module instr_fetch_unit
    import cpu_types_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = RESET_VECTOR,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            imem_rsp_err,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [31:0]     id_instr,
    output logic [XLEN-1:0] id_pc,
    output logic            id_fault
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t    state_q;
    fetch_state_t    state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] target_pc;
    logic            req_hs;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_flush;
    logic            head_valid;
    logic [CW-1:0]   fifo_count;
    logic [CW-1:0]   count_after;
    fetch_entry_t    push_entry;
    fetch_entry_t    head_entry;

    assign imem_req_valid = (state_q == REQ);
    assign imem_req_addr  = (state_q == REQ) ? pc_q : '0;
    assign req_hs         = (state_q == REQ) && imem_req_ready;
    assign fifo_pop       = id_valid && id_ready;
    assign count_after    = fifo_count + CW'(1) - CW'(fifo_pop);

`ifdef IFETCH_MISALIGN_CHK_EN
    logic misaligned;
    assign misaligned = (redirect_pc[1:0] != 2'b00);
    assign target_pc  = redirect_pc;
`else
    assign target_pc  = word_align(redirect_pc);
`endif

    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        fifo_push        = 1'b0;
        fifo_flush       = 1'b0;
        // pc_q already moved past the outstanding request.
        push_entry.pc    = pc_q - XLEN'(4);
        push_entry.instr = imem_rsp_err ? NOP_INSTR : imem_rsp_data;
        push_entry.fault = imem_rsp_err;

        case (state_q)
            IDLE: begin
                if (fifo_count < CW'(FIFO_DEPTH)) state_d = REQ;
            end
            REQ: begin
                if (req_hs) begin
                    pc_d    = pc_q + XLEN'(4);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    fifo_push = 1'b1;
                    state_d   = (count_after < CW'(FIFO_DEPTH)) ? REQ : IDLE;
                end
            end
            DRAIN: begin
                if (imem_rsp_valid) state_d = REQ;
            end
            default: ;
        endcase

        if (redirect_valid) begin
            fifo_flush = 1'b1;
            fifo_push  = 1'b0;
            pc_d       = target_pc;
            case (state_q)
                REQ:     state_d = req_hs ? DRAIN : REQ;
                WAIT:    state_d = imem_rsp_valid ? REQ : DRAIN;
                // A stale response landing with the redirect leaves nothing to wait for.
                DRAIN:   state_d = imem_rsp_valid ? REQ : DRAIN;
                default: state_d = REQ;
            endcase
`ifdef IFETCH_MISALIGN_CHK_EN
            if (misaligned) begin
                fifo_push        = 1'b1;
                push_entry.pc    = redirect_pc;
                push_entry.instr = NOP_INSTR;
                push_entry.fault = 1'b1;
                state_d          = HALT;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (fifo_flush),
        .push       (fifo_push),
        .push_entry (push_entry),
        .pop        (fifo_pop),
        .head_valid (head_valid),
        .head_entry (head_entry),
        .count      (fifo_count)
    );

    assign id_valid = head_valid;
    assign id_instr = head_valid ? head_entry.instr : '0;
    assign id_pc    = head_valid ? XLEN'(head_entry.pc) : '0;
    assign id_fault = head_valid && head_entry.fault;

endmodule
